// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared instruction/data memory (core on port 0, debug loader on port 1).
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(MEM_LAT + 1);
  // WAIT is entered the cycle after ISSUE, so data arrives when cnt reaches MEM_LAT-1
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          winner;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~m0_req;
  end
`else
  logic last_served;

  always_comb begin
    if (m0_req && m1_req) winner = ~last_served;
    else                  winner = ~m0_req;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_served <= 1'b1;
`endif
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner     <= winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_served <= winner;
`endif
            mem_we    <= winner ? m1_we    : m0_we;
            mem_addr  <= winner ? m1_addr  : m0_addr;
            mem_wdata <= winner ? m1_wdata : m0_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= '0;
          if (mem_we) begin
            if (owner) m1_ack <= 1'b1;
            else       m0_ack <= 1'b1;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAST_CNT) begin
            if (owner) begin
              m1_rdata <= mem_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= mem_rdata;
              m0_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic              last_srv;
  logic [DATA_W-1:0] exp_rdata [2];
  logic [DATA_W-1:0] ref_mem [256];

  // Memory environment: read data appears exactly MEM_LAT cycles after mem_en, garbage otherwise
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];
  logic              load_mem = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem)
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    else if (mem_en && mem_we)
      mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic pick(input logic r0, input logic r1);
    if (r0 && r1) return FIXED ? 1'b0 : ~last_srv;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  function automatic int txn_lat(input logic we);
    return we ? 2 : MEM_LAT + 2;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h10] = 32'hDEADBEEF;
    reset = 1'b1; load_mem = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    @(posedge clk); #1;
    load_mem = 1'b0;
    checks++;
    if ({mem_en, mem_we, m0_ack, m1_ack, busy, owner} !== 6'b0)
      $display("FAIL reset_ctrl got %b expected 000000", {mem_en, mem_we, m0_ack, m1_ack, busy, owner});
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_bus got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    checks++;
    if (m0_rdata !== '0 || m1_rdata !== '0)
      $display("FAIL reset_rdata got %h %h expected 0", m0_rdata, m1_rdata);
    errors += (({mem_en, mem_we, m0_ack, m1_ack, busy, owner} !== 6'b0) ? 1 : 0)
            + ((mem_addr !== '0 || mem_wdata !== '0) ? 1 : 0)
            + ((m0_rdata !== '0 || m1_rdata !== '0) ? 1 : 0);
    @(negedge clk); reset = 1'b0;
    last_srv = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic test_random_txns(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] pat, we;
      logic [31:0] a0, a1, d0, d1, ea, ed;
      logic win, ewe;
      int lat, ack_k, en_k, en_cnt;
      pat = 2'($urandom_range(1, 3)); we = 2'($urandom);
      a0 = {24'h0, 8'($urandom)}; a1 = {24'h0, 8'($urandom)};
      d0 = $urandom; d1 = $urandom;
      if (i == 0) begin pat = 2'b01; we = 2'b00; a0 = 32'h10; end
      else if (i == 1) begin pat = 2'b10; we = 2'b10; a1 = 32'h20; d1 = 32'h12345678; end
      else if (i == 2) begin pat = 2'b01; we = 2'b00; a0 = 32'h20; end
      win = pick(pat[0], pat[1]);
      ewe = we[win]; ea = win ? a1 : a0; ed = win ? d1 : d0;
      lat = txn_lat(ewe);
      @(negedge clk);
      m0_req = pat[0]; m0_we = we[0]; m0_addr = a0; m0_wdata = d0;
      m1_req = pat[1]; m1_we = we[1]; m1_addr = a1; m1_wdata = d1;
      ack_k = 0; en_k = 0; en_cnt = 0;
      for (int k = 1; k <= MEM_LAT + 4 && ack_k == 0; k++) begin
        @(posedge clk); #1;
        if (mem_en) begin
          en_cnt++; en_k = k;
          checks++;
          if (mem_we !== ewe || mem_addr !== ea || (ewe && mem_wdata !== ed)) begin
            errors++;
            $display("FAIL issue_fields got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, ewe, ea, ed);
          end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_txn cycle %0d got %b expected 1", k, busy); end
        if (m0_ack || m1_ack) begin
          ack_k = k;
          checks++;
          if (m1_ack !== win || m0_ack !== ~win) begin
            errors++;
            $display("FAIL ack_port got m0=%b m1=%b expected port %0d", m0_ack, m1_ack, win);
          end
        end
      end
      last_srv = win;
      if (ewe) ref_mem[ea[7:0]] = ed;
      else     exp_rdata[win] = ref_mem[ea[7:0]];
      checks++;
      if (en_cnt != 1 || en_k != 1) begin
        errors++; $display("FAIL mem_en_timing got count=%0d cycle=%0d expected count=1 cycle=1", en_cnt, en_k);
      end
      checks++;
      if (ack_k != lat) begin errors++; $display("FAIL ack_latency got %0d expected %0d", ack_k, lat); end
      checks++;
      if (owner !== win) begin errors++; $display("FAIL owner got %b expected %b", owner, win); end
      checks++;
      if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin
        errors++;
        $display("FAIL rdata got %h %h expected %h %h", m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end
      @(negedge clk); m0_req = 0; m1_req = 0;
      @(posedge clk); #1;
      checks++;
      if (m0_ack || m1_ack || busy || mem_en) begin
        errors++;
        $display("FAIL after_ack got ack=%b%b busy=%b en=%b expected 0", m0_ack, m1_ack, busy, mem_en);
      end
    end
  endtask

  task automatic test_drop_and_change();
    logic [31:0] expd;
    int ack_k;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; m1_req = 0;
    expd = ref_mem[8'h10];
    ack_k = 0;
    for (int k = 1; k <= MEM_LAT + 4 && ack_k == 0; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_addr !== 32'h10) begin errors++; $display("FAIL drop_addr got %h expected 00000010", mem_addr); end
      if (m0_ack) ack_k = k;
      checks++;
      if (m1_ack !== 1'b0) begin errors++; $display("FAIL drop_other_ack got %b expected 0", m1_ack); end
      if (k == 2) begin
        @(negedge clk);
        m0_req = 0; m0_we = 1; m0_addr = 32'h55;
      end
    end
    last_srv = 1'b0; exp_rdata[0] = expd;
    checks++;
    if (ack_k != MEM_LAT + 2) begin errors++; $display("FAIL drop_ack got %0d expected %0d", ack_k, MEM_LAT + 2); end
    checks++;
    if (m0_rdata !== expd) begin errors++; $display("FAIL drop_rdata got %h expected %h", m0_rdata, expd); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_en || busy || m0_ack || mem_addr !== 32'h10) begin
        errors++;
        $display("FAIL drop_idle got en=%b busy=%b ack=%b addr=%h expected 0 0 0 00000010", mem_en, busy, m0_ack, mem_addr);
      end
    end
    @(negedge clk); m0_we = 0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] we;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic ew, p;
    int exp_en, exp_ack, nacks;
    we = 2'($urandom);
    for (int i = 0; i < 2; i++) begin a[i] = {24'h0, 8'($urandom)}; d[i] = $urandom; end
    @(negedge clk);
    m0_req = 1; m0_we = we[0]; m0_addr = a[0]; m0_wdata = d[0];
    m1_req = 1; m1_we = we[1]; m1_addr = a[1]; m1_wdata = d[1];
    ew = pick(1'b1, 1'b1); exp_en = 1; exp_ack = txn_lat(we[ew]);
    nacks = 0;
    for (int t = 1; t <= 200 && nacks < 4; t++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        checks++;
        if (t != exp_en) begin errors++; $display("FAIL b2b_issue got cycle %0d expected %0d", t, exp_en); end
      end
      if (m0_ack || m1_ack) begin
        p = m1_ack;
        checks++;
        if (p !== ew || m0_ack === m1_ack) begin
          errors++; $display("FAIL b2b_order ack %0d got m0=%b m1=%b expected port %0d", nacks, m0_ack, m1_ack, ew);
        end
        checks++;
        if (t != exp_ack) begin errors++; $display("FAIL b2b_ack_cycle got %0d expected %0d", t, exp_ack); end
        last_srv = ew;
        if (we[ew]) ref_mem[a[ew][7:0]] = d[ew];
        else        exp_rdata[ew] = ref_mem[a[ew][7:0]];
        checks++;
        if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin
          errors++;
          $display("FAIL b2b_rdata got %h %h expected %h %h", m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
        end
        nacks++;
        ew = pick(1'b1, 1'b1);
        exp_en = t + 2;
        exp_ack = exp_en + txn_lat(we[ew]) - 1;
      end
    end
    checks++;
    if (nacks != 4) begin errors++; $display("FAIL b2b_timeout got %0d acks expected 4", nacks); end
    @(negedge clk); m0_req = 0; m1_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a1, expd;
    int ack_k;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = {24'h0, 8'($urandom)}; m1_req = 0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1; #1;
    checks++;
    if ({mem_en, mem_we, m0_ack, m1_ack, busy, owner} !== 6'b0 || mem_addr !== '0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++;
      $display("FAIL mid_reset got en=%b we=%b ack=%b%b busy=%b owner=%b addr=%h rdata=%h %h expected all 0",
               mem_en, mem_we, m0_ack, m1_ack, busy, owner, mem_addr, m0_rdata, m1_rdata);
    end
    m0_req = 0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    last_srv = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (m0_ack || m1_ack || busy) begin
        errors++; $display("FAIL mid_reset_quiet got ack=%b%b busy=%b expected 0", m0_ack, m1_ack, busy);
      end
    end
    @(negedge clk);
    a1 = {24'h0, 8'($urandom)}; expd = ref_mem[a1[7:0]];
    m1_req = 1; m1_we = 0; m1_addr = a1;
    ack_k = 0;
    for (int k = 1; k <= MEM_LAT + 4 && ack_k == 0; k++) begin
      @(posedge clk); #1;
      if (m1_ack) ack_k = k;
      checks++;
      if (m0_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_m0_ack got %b expected 0", m0_ack); end
    end
    last_srv = 1'b1; exp_rdata[1] = expd;
    checks++;
    if (ack_k != MEM_LAT + 2) begin errors++; $display("FAIL mid_reset_ack got %0d expected %0d", ack_k, MEM_LAT + 2); end
    checks++;
    if (m1_rdata !== expd || m0_rdata !== '0) begin
      errors++; $display("FAIL mid_reset_rdata got %h %h expected 00000000 %h", m0_rdata, m1_rdata, expd);
    end
    @(negedge clk); m1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_random_txns(40);
    test_drop_and_change();
    test_back_to_back();
    test_reset_mid();
    test_random_txns(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
